// File: rtl/cntr8_arbiter.sv
// cntr8_arbiter: round-robin command sequencer for a shared load/inc/dec counter.
// Two requesters issue LOAD, INC-by-N, DEC-by-N or READ commands. The arbiter
// grants one at a time, drives one-cycle counter strobes, then reports the final
// counter value with a done pulse. It is the only driver of the counter controls.
//
// Timing (cycles counted from the edge that samples the request in IDLE):
//   cycle 1            : gnt pulse, first strobe (LOAD data or first INC/DEC step)
//   cycles 1..max(n,1) : RUN, one strobe per cycle for INC/DEC
//   cycle max(n,1)+1   : DONE, done pulse; cnt_q here already includes the last strobe
//   cycle max(n,1)+2   : IDLE again, result holds the value cnt_q had in DONE
// Because every output is registered, result is captured on the edge that closes
// the DONE cycle, so it reads the fully updated counter value.

module cntr8_arbiter #(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             req0,
    input  logic [1:0]       cmd0,
    input  logic [WIDTH-1:0] arg0,
    output logic             gnt0,
    output logic             done0,

    input  logic             req1,
    input  logic [1:0]       cmd1,
    input  logic [WIDTH-1:0] arg1,
    output logic             gnt1,
    output logic             done1,

    input  logic [WIDTH-1:0] cnt_q,
    output logic             cnt_load,
    output logic             cnt_inc,
    output logic             cnt_dec,
    output logic [WIDTH-1:0] cnt_d,

    output logic [WIDTH-1:0] result,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        CMD_LOAD = 2'b00,
        CMD_INC  = 2'b01,
        CMD_DEC  = 2'b10,
        CMD_READ = 2'b11
    } cmd_t;

    // FSM and command context
    state_t             state, state_n;
    cmd_t               cmd_r, cmd_n;      // command of the granted requester
    logic [STEP_W-1:0]  rem, rem_n;        // strobes still to issue after the current one
    logic               owner, owner_n;    // requester that owns the running command
    logic               last, last_n;      // requester served most recently (1 favours req0)

    // Next values of the registered outputs
    logic               gnt0_n, gnt1_n;
    logic               done0_n, done1_n;
    logic               load_n, inc_n, dec_n;
    logic [WIDTH-1:0]   d_n;
    logic [WIDTH-1:0]   result_n;
    logic               busy_n;

    // Winner selection and its command fields
    logic               pick;
    cmd_t               pick_cmd;
    logic [WIDTH-1:0]   pick_arg;
    logic [STEP_W-1:0]  pick_steps;

    // Arbitration: a lone request wins; on contention the requester not served last wins.
    always_comb begin
        pick = 1'b0;
        if (req0 && req1) begin
            pick = ~last;
        end else if (req1) begin
            pick = 1'b1;
        end
        pick_cmd   = cmd_t'(pick ? cmd1 : cmd0);
        pick_arg   = pick ? arg1 : arg0;
        pick_steps = pick_arg[STEP_W-1:0];
    end

    // Next-state and next-output logic for the IDLE/RUN/DONE sequencer.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path through
        // the case statement can leave a value unassigned and infer a latch.
        state_n  = state;
        cmd_n    = cmd_r;
        rem_n    = rem;
        owner_n  = owner;
        last_n   = last;
        gnt0_n   = 1'b0;
        gnt1_n   = 1'b0;
        done0_n  = 1'b0;
        done1_n  = 1'b0;
        load_n   = 1'b0;
        inc_n    = 1'b0;
        dec_n    = 1'b0;
        d_n      = '0;
        result_n = result;

        case (state)
            ST_IDLE: begin
                if (req0 || req1) begin
                    state_n = ST_RUN;
                    owner_n = pick;
                    cmd_n   = pick_cmd;
                    gnt0_n  = ~pick;
                    gnt1_n  = pick;
                    rem_n   = '0;
                    // The first strobe goes out together with the grant.
                    case (pick_cmd)
                        CMD_LOAD: begin
                            load_n = 1'b1;
                            d_n    = pick_arg;
                        end
                        CMD_INC: begin
                            if (pick_steps != '0) begin
                                inc_n = 1'b1;
                                rem_n = pick_steps - STEP_W'(1);
                            end
                        end
                        CMD_DEC: begin
                            if (pick_steps != '0) begin
                                dec_n = 1'b1;
                                rem_n = pick_steps - STEP_W'(1);
                            end
                        end
                        default: begin
                            // READ: one RUN cycle without a strobe
                        end
                    endcase
                end
            end

            ST_RUN: begin
                if (rem == '0) begin
                    state_n = ST_DONE;
                    done0_n = ~owner;
                    done1_n = owner;
                end else begin
                    // rem is only non-zero for INC/DEC, so exactly one of these fires.
                    rem_n = rem - STEP_W'(1);
                    inc_n = (cmd_r == CMD_INC);
                    dec_n = (cmd_r == CMD_DEC);
                end
            end

            ST_DONE: begin
                state_n  = ST_IDLE;
                result_n = cnt_q;
                last_n   = owner;
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase

        busy_n = (state_n != ST_IDLE);
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the values from before this edge, independent of statement order.
        if (reset) begin
            state    <= ST_IDLE;
            cmd_r    <= CMD_READ;
            rem      <= '0;
            owner    <= 1'b0;
            last     <= 1'b1;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            done0    <= 1'b0;
            done1    <= 1'b0;
            cnt_load <= 1'b0;
            cnt_inc  <= 1'b0;
            cnt_dec  <= 1'b0;
            cnt_d    <= '0;
            result   <= '0;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            cmd_r    <= cmd_n;
            rem      <= rem_n;
            owner    <= owner_n;
            last     <= last_n;
            gnt0     <= gnt0_n;
            gnt1     <= gnt1_n;
            done0    <= done0_n;
            done1    <= done1_n;
            cnt_load <= load_n;
            cnt_inc  <= inc_n;
            cnt_dec  <= dec_n;
            cnt_d    <= d_n;
            result   <= result_n;
            busy     <= busy_n;
        end
    end

endmodule

// File: tb/tb_cntr8_arbiter.sv
// Testbench for cntr8_arbiter: table-driven vectors, randomized transactions
// against a transaction-level reference model, and hand-written sequences for
// reset priority, held-request contention and mid-operation reset.

module tb_cntr8_arbiter;

    localparam logic [1:0] CMD_LOAD = 2'b00;
    localparam logic [1:0] CMD_INC  = 2'b01;
    localparam logic [1:0] CMD_DEC  = 2'b10;
    localparam logic [1:0] CMD_READ = 2'b11;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0, req1;
    logic [1:0] cmd0, cmd1;
    logic [7:0] arg0, arg1;
    logic       gnt0, gnt1, done0, done1;
    logic [7:0] cnt_q;
    logic       cnt_load, cnt_inc, cnt_dec;
    logic [7:0] cnt_d;
    logic [7:0] result;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: counter value and requester served last.
    int m_cnt  = 0;
    int m_last = 1;

    typedef struct {
        logic       r0;
        logic [1:0] c0;
        logic [7:0] a0;
        logic       r1;
        logic [1:0] c1;
        logic [7:0] a1;
        int         owner;
        logic [7:0] res;
    } vec_t;

    vec_t tbl[14];

    cntr8_arbiter #(.WIDTH(8), .STEP_W(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .req0     (req0),
        .cmd0     (cmd0),
        .arg0     (arg0),
        .gnt0     (gnt0),
        .done0    (done0),
        .req1     (req1),
        .cmd1     (cmd1),
        .arg1     (arg1),
        .gnt1     (gnt1),
        .done1    (done1),
        .cnt_q    (cnt_q),
        .cnt_load (cnt_load),
        .cnt_inc  (cnt_inc),
        .cnt_dec  (cnt_dec),
        .cnt_d    (cnt_d),
        .result   (result),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // The cntr8 datapath the arbiter controls.
    always @(posedge clk) begin
        if (reset)         cnt_q <= 8'h00;
        else if (cnt_load) cnt_q <= cnt_d;
        else if (cnt_inc)  cnt_q <= cnt_q + 8'd1;
        else if (cnt_dec)  cnt_q <= cnt_q - 8'd1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int model_steps(input logic [1:0] c, input logic [7:0] a);
        if (c == CMD_INC || c == CMD_DEC) return int'(a) % 16;
        return 0;
    endfunction

    function automatic int model_pick(input logic r0, input logic r1);
        if (r0 && r1) return (m_last == 0) ? 1 : 0;
        return r0 ? 0 : 1;
    endfunction

    task automatic model_apply(input int who, input logic [1:0] c, input logic [7:0] a);
        int s;
        s = model_steps(c, a);
        case (c)
            CMD_LOAD: m_cnt = int'(a);
            CMD_INC:  m_cnt = (m_cnt + s) % 256;
            CMD_DEC:  m_cnt = (m_cnt + 256 - s) % 256;
            default:  ;
        endcase
        m_last = who;
    endtask

    // Caller is at a negedge with the DUT idle. Drives the requests, checks the
    // grant, strobes, done pulse and latency, then the captured result.
    task automatic run_txn(input string tag,
                           input logic r0, input logic [1:0] c0, input logic [7:0] a0,
                           input logic r1, input logic [1:0] c1, input logic [7:0] a1,
                           input int exp_owner, input logic [7:0] exp_res);
        int wait_cyc, cyc, n_load, n_inc, n_dec, n_over, n_bad_d;
        int owner, done_owner, steps, exp_lat;
        logic [1:0] wc;
        logic [7:0] wa, seen_d;
        wc = (exp_owner == 1) ? c1 : c0;
        wa = (exp_owner == 1) ? a1 : a0;
        steps   = model_steps(wc, wa);
        exp_lat = (steps > 1) ? steps : 1;

        req0 = r0; cmd0 = c0; arg0 = a0;
        req1 = r1; cmd1 = c1; arg1 = a1;
        owner = -1;
        wait_cyc = 0;
        while (owner < 0 && wait_cyc < 8) begin
            @(negedge clk);
            wait_cyc++;
            if (gnt0 && gnt1)  owner = 2;
            else if (gnt0)     owner = 0;
            else if (gnt1)     owner = 1;
        end
        req0 = 1'b0;
        req1 = 1'b0;
        check({tag, " grant owner"}, owner, exp_owner);
        check({tag, " grant latency"}, wait_cyc, 1);
        if (owner < 0) return;

        n_load = 0; n_inc = 0; n_dec = 0; n_over = 0; n_bad_d = 0;
        done_owner = -1;
        cyc = 0;
        seen_d = 8'h00;
        while (done_owner < 0 && cyc < 40) begin
            if (cnt_load) begin
                n_load++;
                seen_d = cnt_d;
            end else if (cnt_d != 8'h00) begin
                n_bad_d++;
            end
            if (cnt_inc) n_inc++;
            if (cnt_dec) n_dec++;
            if (int'(cnt_load) + int'(cnt_inc) + int'(cnt_dec) > 1) n_over++;
            if (done0 && done1) done_owner = 2;
            else if (done0)     done_owner = 0;
            else if (done1)     done_owner = 1;
            if (done_owner < 0) begin
                @(negedge clk);
                cyc++;
            end
        end
        check({tag, " done owner"}, done_owner, exp_owner);
        check({tag, " done latency"}, cyc, exp_lat);
        check({tag, " load strobes"}, n_load, (wc == CMD_LOAD) ? 1 : 0);
        check({tag, " inc strobes"}, n_inc, (wc == CMD_INC) ? steps : 0);
        check({tag, " dec strobes"}, n_dec, (wc == CMD_DEC) ? steps : 0);
        check({tag, " strobe overlap"}, n_over, 0);
        check({tag, " cnt_d idle zero"}, n_bad_d, 0);
        if (wc == CMD_LOAD) check({tag, " cnt_d"}, seen_d, wa);

        @(negedge clk);
        check({tag, " result"}, result, exp_res);
        check({tag, " busy after"}, busy, 1'b0);
        check({tag, " done single pulse"}, {done0, done1}, 2'b00);
    endtask

    initial begin
        int gq[$];
        int dq[$];
        int ov, cyc, exp_o, n_done, n_gnt;
        logic r0, r1;
        logic [1:0] c0, c1;
        logic [7:0] a0, a1;

        tbl[0]  = '{1'b1, CMD_LOAD, 8'h5A, 1'b0, CMD_READ, 8'h00, 0, 8'h5A};
        tbl[1]  = '{1'b1, CMD_LOAD, 8'hFE, 1'b0, CMD_READ, 8'h00, 0, 8'hFE};
        tbl[2]  = '{1'b0, CMD_READ, 8'h00, 1'b1, CMD_INC,  8'h03, 1, 8'h01};
        tbl[3]  = '{1'b1, CMD_INC,  8'h00, 1'b0, CMD_READ, 8'h00, 0, 8'h01};
        tbl[4]  = '{1'b0, CMD_READ, 8'h00, 1'b1, CMD_LOAD, 8'h33, 1, 8'h33};
        tbl[5]  = '{1'b1, CMD_READ, 8'h00, 1'b0, CMD_READ, 8'h00, 0, 8'h33};
        tbl[6]  = '{1'b0, CMD_READ, 8'h00, 1'b1, CMD_DEC,  8'hF2, 1, 8'h31};
        tbl[7]  = '{1'b1, CMD_DEC,  8'h02, 1'b1, CMD_INC,  8'h01, 0, 8'h2F};
        tbl[8]  = '{1'b1, CMD_DEC,  8'h02, 1'b1, CMD_INC,  8'h01, 1, 8'h30};
        tbl[9]  = '{1'b1, CMD_DEC,  8'h02, 1'b1, CMD_INC,  8'h01, 0, 8'h2E};
        tbl[10] = '{1'b1, CMD_INC,  8'h1F, 1'b0, CMD_READ, 8'h00, 0, 8'h3D};
        tbl[11] = '{1'b0, CMD_READ, 8'h00, 1'b1, CMD_DEC,  8'h40, 1, 8'h3D};
        tbl[12] = '{1'b1, CMD_LOAD, 8'h01, 1'b0, CMD_READ, 8'h00, 0, 8'h01};
        tbl[13] = '{1'b0, CMD_READ, 8'h00, 1'b1, CMD_DEC,  8'h03, 1, 8'hFE};

        // Reset held with both requests active: nothing may be granted or strobed.
        reset = 1'b1;
        req0 = 1'b1; cmd0 = CMD_READ; arg0 = 8'h00;
        req1 = 1'b1; cmd1 = CMD_READ; arg1 = 8'h00;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset gnt", {gnt0, gnt1}, 2'b00);
            check("reset strobes", {cnt_load, cnt_inc, cnt_dec}, 3'b000);
            check("reset done/busy", {done0, done1, busy}, 3'b000);
            check("reset result", result, 8'h00);
        end
        reset = 1'b0;
        // First grant after release goes to req0.
        exp_o = model_pick(1'b1, 1'b1);
        model_apply(exp_o, CMD_READ, 8'h00);
        run_txn("post-reset", 1'b1, CMD_READ, 8'h00, 1'b1, CMD_READ, 8'h00, 0, 8'h00);

        // Directed vectors.
        foreach (tbl[i]) begin
            model_apply(tbl[i].owner, (tbl[i].owner == 1) ? tbl[i].c1 : tbl[i].c0,
                        (tbl[i].owner == 1) ? tbl[i].a1 : tbl[i].a0);
            run_txn($sformatf("vec%0d", i), tbl[i].r0, tbl[i].c0, tbl[i].a0,
                    tbl[i].r1, tbl[i].c1, tbl[i].a1, tbl[i].owner, tbl[i].res);
        end

        // Randomized transactions against the reference model.
        for (int i = 0; i < 40; i++) begin
            r0 = 1'($urandom_range(0, 1));
            r1 = 1'($urandom_range(0, 1));
            if (!r0 && !r1) r0 = 1'b1;
            c0 = 2'($urandom_range(0, 3));
            c1 = 2'($urandom_range(0, 3));
            a0 = 8'($urandom_range(0, 255));
            a1 = 8'($urandom_range(0, 255));
            exp_o = model_pick(r0, r1);
            model_apply(exp_o, (exp_o == 1) ? c1 : c0, (exp_o == 1) ? a1 : a0);
            run_txn($sformatf("rnd%0d", i), r0, c0, a0, r1, c1, a1, exp_o, 8'(m_cnt));
        end

        // Contention with both requests held high across four commands.
        req0 = 1'b1; cmd0 = CMD_DEC; arg0 = 8'h02;
        req1 = 1'b1; cmd1 = CMD_INC; arg1 = 8'h01;
        ov = 0;
        cyc = 0;
        while (dq.size() < 4 && cyc < 80) begin
            @(negedge clk);
            cyc++;
            if (gnt0)  gq.push_back(0);
            if (gnt1)  gq.push_back(1);
            if (done0) dq.push_back(0);
            if (done1) dq.push_back(1);
            if (int'(cnt_load) + int'(cnt_inc) + int'(cnt_dec) > 1) ov++;
        end
        req0 = 1'b0;
        req1 = 1'b0;
        check("hold done count", dq.size(), 4);
        check("hold grant count", gq.size(), 4);
        check("hold overlap", ov, 0);
        for (int k = 0; k < 4; k++) begin
            exp_o = model_pick(1'b1, 1'b1);
            model_apply(exp_o, (exp_o == 1) ? CMD_INC : CMD_DEC, (exp_o == 1) ? 8'h01 : 8'h02);
            check($sformatf("hold grant%0d", k), (k < gq.size()) ? gq[k] : -1, exp_o);
            check($sformatf("hold done%0d", k), (k < dq.size()) ? dq[k] : -1, exp_o);
        end
        @(negedge clk);
        check("hold result", result, 8'(m_cnt));

        // Make req0 the last served, so only reset can give it priority again.
        model_apply(0, CMD_READ, 8'h00);
        run_txn("pre-abort read", 1'b1, CMD_READ, 8'h00, 1'b0, CMD_READ, 8'h00, 0, 8'(m_cnt));

        // Reset during the third strobe of INC 10.
        req0 = 1'b1; cmd0 = CMD_INC; arg0 = 8'h0A;
        @(negedge clk);
        check("abort gnt0", gnt0, 1'b1);
        check("abort strobe1", cnt_inc, 1'b1);
        req0 = 1'b0;
        @(negedge clk);
        check("abort strobe2", cnt_inc, 1'b1);
        @(negedge clk);
        check("abort strobe3", cnt_inc, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        check("abort strobes off", {cnt_load, cnt_inc, cnt_dec}, 3'b000);
        check("abort busy", busy, 1'b0);
        check("abort result", result, 8'h00);
        check("abort done", {done0, done1}, 2'b00);
        reset = 1'b0;
        m_cnt  = 0;
        m_last = 1;
        n_done = 0;
        n_gnt  = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done0 || done1) n_done++;
            if (gnt0 || gnt1) n_gnt++;
        end
        check("abort no late done", n_done, 0);
        check("abort no spurious gnt", n_gnt, 0);
        exp_o = model_pick(1'b1, 1'b1);
        model_apply(exp_o, CMD_READ, 8'h00);
        run_txn("after abort", 1'b1, CMD_READ, 8'h00, 1'b1, CMD_READ, 8'h00, 0, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
